rpn_evaluator: RTL and testbench

RPN_EVALUATOR -- requirements
Module: rpn_evaluator

---
 rtl/rpn_if.sv | 30 +++
 rtl/rpn_evaluator.sv | 275 +++++++++++++++++++++++++++
 tb/tb_rpn_evaluator.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_if.sv
// Bus between the RPN evaluator and its controller / token memory.
// Handshake: start is a single-cycle request that is honoured only while the
// evaluator is idle; busy rises on the cycle after an accepted start and falls
// on the same cycle as the one-cycle done pulse; result and error are valid
// with done and stay stable until the next accepted start. queue_data must
// present the token at queue_index one cycle after queue_index changes.
interface rpn_if #(
  parameter int NW = 16,
  parameter int IW = 6
);
  logic          start;
  logic [NW-1:0] x;
  logic [IW:0]   expr_len;
  logic [IW-1:0] queue_index;
  logic [NW:0]   queue_data;
  logic          busy;
  logic          done;
  logic [NW-1:0] result;
  logic          error;

  modport master (
    output start, x, expr_len, queue_data,
    input  queue_index, busy, done, result, error
  );

  modport slave (
    input  start, x, expr_len, queue_data,
    output queue_index, busy, done, result, error
  );
endinterface

// File: rtl/rpn_evaluator.sv
// Reverse-Polish expression evaluator over signed Q(I).(F) fixed-point values.
// Tokens are fetched one at a time from an external queue; operands and the
// variable x are pushed on an internal stack, binary operators pop two values
// and push one. Multiply takes two cycles, divide is a bit-serial restoring
// divider, power is repeated fixed-point multiplication.
module rpn_evaluator #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int OUTPUT_QUEUE_SIZE     = 64,
  parameter int STACK_SIZE            = 16
) (
  input  logic       clk,
  input  logic       rst,
  rpn_if.slave       bus,
  output logic [2:0] state_dbg
);
  localparam int NW        = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam int FW        = FRACTIONAL_PART_WIDTH;
  localparam int IW        = $clog2(OUTPUT_QUEUE_SIZE);
  localparam int SAW       = $clog2(STACK_SIZE);
  localparam int SPW       = $clog2(STACK_SIZE + 1);
  localparam int DW        = NW + FW;
  localparam int POW_LIM   = INTEGER_PART_WIDTH * 4;
  localparam int CW        = $clog2(DW + POW_LIM + 1);
  localparam logic [NW-1:0] ONE_Q = NW'(1) << FW;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;
  localparam logic [2:0] OP_VAR = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_MUL, S_DIV, S_POW, S_FINISH
  } state_t;

  // Signed fixed-point multiply: full product, keep the window aligned to F.
  function automatic logic [NW-1:0] qmul(input logic [NW-1:0] a, input logic [NW-1:0] b);
    logic signed [2*NW-1:0] p;
    p = $signed({{NW{a[NW-1]}}, a}) * $signed({{NW{b[NW-1]}}, b});
    return p[NW+FW-1:FW];
  endfunction

  state_t        state_q, state_d;
  logic [NW-1:0] x_q, x_d;
  logic [IW:0]   len_q, len_d;
  logic [IW:0]   idx_q, idx_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [NW-1:0] stack_q [STACK_SIZE];
  logic [NW-1:0] stack_d [STACK_SIZE];
  logic [NW-1:0] a_q, a_d;
  logic [NW-1:0] b_q, b_d;
  logic [NW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW:0]   rem_q, rem_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] quo_q, quo_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [NW-1:0] result_q, result_d;

  logic [SAW-1:0] top_a, sec_a, push_a;
  logic [NW-1:0]  top_v, sec_v, mag_a, mag_b, push_v, div_q;
  logic [NW:0]    rem_sh;
  logic           rem_ge;
  logic [DW-1:0]  quo_n;
  logic [2:0]     op_code;
  logic           is_push;
  int             n_val;
  logic           bin_done;
  logic [NW-1:0]  bin_res;

  // Next-state, datapath and output computation for the evaluation FSM.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sp_d     = sp_q;
    stack_d  = stack_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    result_d = result_q;
    bin_done = 1'b0;
    bin_res  = '0;

    top_a   = SAW'(sp_q - SPW'(1));
    sec_a   = SAW'(sp_q - SPW'(2));
    push_a  = SAW'(sp_q);
    top_v   = stack_q[top_a];
    sec_v   = stack_q[sec_a];
    mag_a   = sec_v[NW-1] ? (~sec_v + 1'b1) : sec_v;
    mag_b   = top_v[NW-1] ? (~top_v + 1'b1) : top_v;
    n_val   = int'($signed(top_v[NW-1:FW]));
    op_code = bus.queue_data[2:0];
    is_push = !bus.queue_data[NW] || (op_code == OP_VAR);
    push_v  = bus.queue_data[NW] ? x_q : bus.queue_data[NW-1:0];

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    rem_sh  = {rem_q[NW-1:0], dvd_q[DW-1]};
    rem_ge  = rem_sh >= {1'b0, b_q};
    quo_n   = {quo_q[DW-2:0], rem_ge};
    div_q   = quo_n[NW-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = bus.x;
          len_d   = bus.expr_len;
          idx_d   = '0;
          sp_d    = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = (idx_q == len_q) ? S_FINISH : S_WAIT;
      S_WAIT:  state_d = S_EXEC;
      S_EXEC: begin
        if (is_push) begin
          if (sp_q == SPW'(STACK_SIZE)) begin
            error_d = 1'b1;
            state_d = S_FINISH;
          end else begin
            stack_d[push_a] = push_v;
            sp_d    = sp_q + 1'b1;
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (op_code == 3'd5 || op_code == 3'd7) begin
          // Unknown operator: flag it, skip the token, keep evaluating.
          error_d = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end else if (sp_q < SPW'(2)) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          a_d = sec_v;
          b_d = top_v;
          unique case (op_code)
            OP_ADD: begin bin_done = 1'b1; bin_res = sec_v + top_v; end
            OP_SUB: begin bin_done = 1'b1; bin_res = sec_v - top_v; end
            OP_MUL: state_d = S_MUL;
            OP_DIV: begin
              if (top_v == '0) begin
                error_d  = 1'b1;
                bin_done = 1'b1;
                bin_res  = '0;
              end else begin
                b_d     = mag_b;
                dvd_d   = {mag_a, {FW{1'b0}}};
                rem_d   = '0;
                quo_d   = '0;
                neg_d   = sec_v[NW-1] ^ top_v[NW-1];
                cnt_d   = CW'(DW);
                state_d = S_DIV;
              end
            end
            default: begin
              if (n_val <= 0) begin
                bin_done = 1'b1;
                bin_res  = ONE_Q;
              end else begin
                acc_d   = ONE_Q;
                cnt_d   = CW'((n_val > POW_LIM) ? POW_LIM : n_val);
                state_d = S_POW;
              end
            end
          endcase
        end
      end
      S_MUL: begin
        bin_done = 1'b1;
        bin_res  = qmul(a_q, b_q);
      end
      S_DIV: begin
        rem_d = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
        dvd_d = dvd_q << 1;
        quo_d = quo_n;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          bin_done = 1'b1;
          bin_res  = neg_q ? (~div_q + 1'b1) : div_q;
        end
      end
      S_POW: begin
        acc_d = qmul(acc_q, a_q);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          bin_done = 1'b1;
          bin_res  = qmul(acc_q, a_q);
        end
      end
      S_FINISH: begin
        result_d = (sp_q == '0) ? '0 : stack_q[top_a];
        error_d  = error_q | (sp_q != SPW'(1));
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A completed binary op replaces the two operands with its result.
    if (bin_done) begin
      stack_d[sec_a] = bin_res;
      sp_d    = sp_q - 1'b1;
      idx_d   = idx_q + 1'b1;
      state_d = S_FETCH;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      sp_q     <= '0;
      for (int i = 0; i < STACK_SIZE; i++) stack_q[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      sp_q     <= sp_d;
      stack_q  <= stack_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  assign bus.queue_index = idx_q[IW-1:0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.error       = error_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator: an abstract stack-machine model predicts
// result, error and completion latency for each token list; a compare process
// checks busy/done every cycle of a run and result/error at done.
module tb_rpn_evaluator;
  localparam int NW = 16;
  localparam int FW = 8;
  localparam int IW = 6;
  localparam int QS = 64;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  rpn_if #(.NW(NW), .IW(IW)) bus ();

  rpn_evaluator dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Token memory with one cycle of read latency.
  logic [NW:0] mem [QS];
  always @(posedge clk) bus.queue_data <= mem[bus.queue_index];

  // Scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [NW-1:0] exp_q[$];
  logic          exp_err_q[$];
  int            exp_lat;
  bit            run_on = 1'b0;
  int            run_cyc;
  string         cur_name = "reset";
  logic [NW:0]   tk[$];
  logic [NW-1:0] sb_res;
  logic          sb_err;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_name, what, act, exp);
    end
  endtask

  function automatic logic [NW:0] opnd(input logic [NW-1:0] v);
    return {1'b0, v};
  endfunction

  function automatic logic [NW:0] opr(input logic [2:0] c);
    return {1'b1, {(NW-3){1'b0}}, c};
  endfunction

  // floor(a*b / 2^F) in plain integer arithmetic, wrapped to NW bits.
  function automatic logic [NW-1:0] qm(input logic [NW-1:0] a, input logic [NW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> FW;
    return p[NW-1:0];
  endfunction

  // Abstract evaluation of tk: value stack as a queue plus cycle accounting
  // (3 cycles per token, extra cycles for mul/div/pow, 2 to finish normally,
  // 1 after an aborting token).
  task automatic model_eval(input logic [NW-1:0] xv, output logic [NW-1:0] r,
                            output logic e, output int lat);
    logic [NW-1:0] st[$];
    logic [NW-1:0] a, b, v;
    logic [NW:0]   t;
    bit            abort;
    int            n, ma, mb, q;
    lat = 0; e = 1'b0; abort = 1'b0;
    for (int i = 0; i < tk.size() && !abort; i++) begin
      t = tk[i];
      lat += 3;
      if (!t[NW] || t[2:0] == 3'd6) begin
        if (st.size() == 16) begin e = 1'b1; abort = 1'b1; end
        else st.push_back(t[NW] ? xv : t[NW-1:0]);
      end else if (t[2:0] == 3'd5 || t[2:0] == 3'd7) begin
        e = 1'b1;
      end else if (st.size() < 2) begin
        e = 1'b1; abort = 1'b1;
      end else begin
        b = st.pop_back();
        a = st.pop_back();
        case (t[2:0])
          3'd0: v = a + b;
          3'd1: v = a - b;
          3'd2: begin v = qm(a, b); lat += 1; end
          3'd3: begin
            if (b == '0) begin
              e = 1'b1; v = '0;
            end else begin
              ma = int'($signed(a)); if (ma < 0) ma = -ma;
              mb = int'($signed(b)); if (mb < 0) mb = -mb;
              q = (ma * 256) / mb;
              v = q[NW-1:0];
              if (a[NW-1] ^ b[NW-1]) v = -v;
              lat += NW + FW;
            end
          end
          default: begin
            n = int'($signed(b)) >>> FW;
            v = 16'h0100;
            if (n > 0) begin
              if (n > 32) n = 32;
              for (int k = 0; k < n; k++) v = qm(v, a);
              lat += n;
            end
          end
        endcase
        st.push_back(v);
      end
    end
    lat += abort ? 1 : 2;
    r = (st.size() != 0) ? st[st.size()-1] : '0;
    if (st.size() != 1) e = 1'b1;
  endtask

  // Per-cycle compare of busy/done, result/error at the done cycle.
  always @(posedge clk) begin
    #1;
    if (run_on) begin
      check("busy", {31'b0, bus.busy}, {31'b0, run_cyc < exp_lat});
      check("done", {31'b0, bus.done}, {31'b0, run_cyc == exp_lat});
      if (run_cyc == exp_lat) begin
        sb_res = exp_q.pop_front();
        sb_err = exp_err_q.pop_front();
        check("result", {16'b0, bus.result}, {16'b0, sb_res});
        check("error", {31'b0, bus.error}, {31'b0, sb_err});
        run_on = 1'b0;
      end
      run_cyc++;
    end
  end

  task automatic run_case(input string name, input logic [NW-1:0] xv, input logic [NW-1:0] pin_res,
                          input logic pin_err, input bit poke);
    logic [NW-1:0] mr;
    logic me;
    int ml, g;
    cur_name = name;
    for (int i = 0; i < tk.size(); i++) mem[i] = tk[i];
    model_eval(xv, mr, me, ml);
    check("model_res", {16'b0, mr}, {16'b0, pin_res});
    check("model_err", {31'b0, me}, {31'b0, pin_err});
    exp_q.push_back(mr);
    exp_err_q.push_back(me);
    exp_lat = ml;
    @(negedge clk);
    bus.x = xv;
    bus.expr_len = 7'(tk.size());
    bus.start = 1'b1;
    run_cyc = 0;
    run_on = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (poke) begin
      repeat (3) @(negedge clk);
      bus.x = 16'h1234;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    g = 0;
    while (run_on && g < 3000) begin @(negedge clk); g++; end
    if (run_on) begin
      n_cmp++; n_bad++;
      $display("FAIL %s/timeout: done not seen within %0d cycles", name, g);
      run_on = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("held_res", {16'b0, bus.result}, {16'b0, mr});
    check("held_err", {31'b0, bus.error}, {31'b0, me});
    check("idle_busy", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.x = '0;
    bus.expr_len = '0;
    for (int i = 0; i < QS; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_error", {31'b0, bus.error}, 32'd0);
    check("rst_result", {16'b0, bus.result}, 32'd0);
    check("rst_qidx", {26'b0, bus.queue_index}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    tk = '{opnd(16'h0200), opnd(16'h0300), opr(3'd0)};
    run_case("add", 16'h0000, 16'h0500, 1'b0, 1'b0);
    tk = '{opr(3'd6), opr(3'd6), opr(3'd2), opnd(16'h0180), opr(3'd1)};
    run_case("xx_mul_sub", 16'h0300, 16'h0780, 1'b0, 1'b1);
    tk = '{opnd(16'h0100), opnd(16'h0000), opr(3'd3)};
    run_case("div_zero", 16'h0000, 16'h0000, 1'b1, 1'b0);
    tk = '{opnd(16'h0100), opnd(16'h0300), opr(3'd3)};
    run_case("div_third", 16'h0000, 16'h0055, 1'b0, 1'b0);
    tk = '{opr(3'd6), opnd(16'h0300), opr(3'd4)};
    run_case("pow_neg", 16'hFE00, 16'hF800, 1'b0, 1'b0);
    tk = '{opr(3'd0)};
    run_case("underflow", 16'h0000, 16'h0000, 1'b1, 1'b0);
    tk.delete();
    for (int i = 0; i < 17; i++) tk.push_back(opnd(16'((i + 1) * 256)));
    run_case("overflow", 16'h0000, 16'h1000, 1'b1, 1'b0);
    tk.delete();
    run_case("empty", 16'h0000, 16'h0000, 1'b1, 1'b0);
    tk = '{opnd(16'hFD00), opnd(16'h0200), opr(3'd3)};
    run_case("div_signed", 16'h0000, 16'hFE80, 1'b0, 1'b0);
    tk = '{opnd(16'h7F00), opnd(16'h0100), opr(3'd0)};
    run_case("add_wrap", 16'h0000, 16'h8000, 1'b0, 1'b0);
    tk = '{opnd(16'h0180), opnd(16'h0280), opr(3'd4)};
    run_case("pow_frac_exp", 16'h0000, 16'h0240, 1'b0, 1'b0);
    tk = '{opnd(16'h0100), opnd(16'h6400), opr(3'd4)};
    run_case("pow_clamp", 16'h0000, 16'h0100, 1'b0, 1'b0);
    tk = '{opr(3'd6), opnd(16'h0000), opr(3'd4)};
    run_case("pow_zero", 16'h0500, 16'h0100, 1'b0, 1'b0);
    tk = '{opnd(16'h0100), opr(3'd5)};
    run_case("bad_op", 16'h0000, 16'h0100, 1'b1, 1'b0);
    tk = '{opnd(16'h0100), opnd(16'h0200)};
    run_case("leftover", 16'h0000, 16'h0200, 1'b1, 1'b0);
    tk = '{opnd(16'h0200), opnd(16'h0300), opnd(16'h0400), opr(3'd2), opr(3'd1)};
    run_case("mul_sub", 16'h0000, 16'hF600, 1'b0, 1'b0);

    // Reset during a divide: outputs clear at once, no done afterwards.
    cur_name = "rst_in_div";
    tk = '{opnd(16'h0100), opnd(16'h0300), opr(3'd3)};
    for (int i = 0; i < tk.size(); i++) mem[i] = tk[i];
    @(negedge clk);
    bus.expr_len = 7'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_before", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("busy", {31'b0, bus.busy}, 32'd0);
    check("done", {31'b0, bus.done}, 32'd0);
    check("qidx", {26'b0, bus.queue_index}, 32'd0);
    check("result", {16'b0, bus.result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("no_done", {31'b0, bus.done}, 32'd0);
    end

    // start together with reset: reset wins, nothing starts.
    cur_name = "rst_and_start";
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy", {31'b0, bus.busy}, 32'd0);

    tk = '{opnd(16'h0200), opnd(16'h0300), opr(3'd0)};
    run_case("add_after_rst", 16'h0000, 16'h0500, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
